// File: rtl/ccsds123_stim_gen.sv
// CCSDS-123 test-image stimulus generator: streams one NX*NY*NZ image in BIP order over AXI-Stream.
// Optional running checksum output is enabled with `define CCSDS123_STIM_CHECKSUM_EN.
module ccsds123_stim_gen #(
  parameter int unsigned D    = 16,
  parameter int unsigned NX   = 4,
  parameter int unsigned NY   = 4,
  parameter int unsigned NZ   = 16,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         start,
  input  logic [1:0]   pattern_sel,
  input  logic [1:0]   throttle,
  output logic [D-1:0] m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tuser,
  output logic         m_axis_tlast,
  output logic         busy,
  output logic         done
`ifdef CCSDS123_STIM_CHECKSUM_EN
  ,
  output logic [31:0]  checksum
`endif
);

  localparam int unsigned N  = NX * NY * NZ;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned XW = (NX > 1) ? $clog2(NX) : 1;
  localparam int unsigned YW = (NY > 1) ? $clog2(NY) : 1;
  localparam int unsigned ZW = (NZ > 1) ? $clog2(NZ) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     pat_q, pat_d;
  logic [1:0]     thr_q, thr_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [ZW-1:0]  z_q, z_d;
  logic [15:0]    dlfsr_q, dlfsr_d;
  logic [15:0]    glfsr_q, glfsr_d;
  logic [D-1:0]   tdata_d;
  logic           tvalid_d, tuser_d, tlast_d, busy_d, done_d;
  logic           hs, eligible;

  // Fibonacci x^16+x^14+x^13+x^11+1, right-shifting form
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [D-1:0] beat_data(input logic [1:0] pat, input logic [IW-1:0] idx,
                                             input logic px, input logic py, input logic pz,
                                             input logic [15:0] l);
    case (pat)
      2'd0:    return D'(idx);
      2'd1:    return {D{1'b1}};
      2'd2:    return D'(l);
      default: return (px ^ py ^ pz) ? {D{1'b1}} : {D{1'b0}};
    endcase
  endfunction

  assign hs = m_axis_tvalid & m_axis_tready;

  always_comb begin
    case (thr_q)
      2'd0:    eligible = 1'b1;
      2'd1:    eligible = glfsr_q[0];
      2'd2:    eligible = (glfsr_q[1:0] == 2'b00);
      default: eligible = (glfsr_q[2:0] == 3'b000);
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q       <= ST_IDLE;
      pat_q         <= '0;
      thr_q         <= '0;
      idx_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      z_q           <= '0;
      dlfsr_q       <= SEED;
      glfsr_q       <= SEED;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      thr_q         <= thr_d;
      idx_q         <= idx_d;
      x_q           <= x_d;
      y_q           <= y_d;
      z_q           <= z_d;
      dlfsr_q       <= dlfsr_d;
      glfsr_q       <= glfsr_d;
      m_axis_tdata  <= tdata_d;
      m_axis_tvalid <= tvalid_d;
      m_axis_tuser  <= tuser_d;
      m_axis_tlast  <= tlast_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

  // Counters and data LFSR always describe the beat currently presented (or next to present);
  // on a handshake the next beat is built from the advanced values so there are no bubbles.
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    thr_d    = thr_q;
    idx_d    = idx_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    dlfsr_d  = dlfsr_q;
    glfsr_d  = glfsr_q;
    tdata_d  = m_axis_tdata;
    tvalid_d = m_axis_tvalid;
    tuser_d  = m_axis_tuser;
    tlast_d  = m_axis_tlast;

    unique case (state_q)
      ST_IDLE: begin
        tvalid_d = 1'b0;
        if (start) begin
          state_d = ST_RUN;
          pat_d   = pattern_sel;
          thr_d   = throttle;
          idx_d   = '0;
          x_d     = '0;
          y_d     = '0;
          z_d     = '0;
          dlfsr_d = SEED;
          glfsr_d = SEED;
        end
      end
      ST_RUN: begin
        glfsr_d = lfsr_step(glfsr_q);
        if (hs) begin
          idx_d   = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
          dlfsr_d = lfsr_step(dlfsr_q);
          if (z_q == ZW'(NZ - 1)) begin
            z_d = '0;
            if (x_q == XW'(NX - 1)) begin
              x_d = '0;
              y_d = (y_q == YW'(NY - 1)) ? '0 : y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end else begin
            z_d = z_q + ZW'(1);
          end
        end
        if (hs && m_axis_tlast) begin
          state_d  = ST_DONE;
          tvalid_d = 1'b0;
          tuser_d  = 1'b0;
          tlast_d  = 1'b0;
        end else if (!m_axis_tvalid || hs) begin
          tvalid_d = eligible;
          if (eligible) begin
            tdata_d = beat_data(pat_q, idx_d, x_d[0], y_d[0], z_d[0], dlfsr_d);
            tuser_d = (idx_d == '0);
            tlast_d = (idx_d == IW'(N - 1));
          end
        end
      end
      ST_DONE: begin
        tvalid_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

`ifdef CCSDS123_STIM_CHECKSUM_EN
  // Running sum of accepted samples for the current image
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      checksum <= '0;
    end else if (state_q == ST_IDLE && start) begin
      checksum <= '0;
    end else if (state_q == ST_RUN && hs) begin
      checksum <= checksum + 32'(m_axis_tdata);
    end
  end
`endif

endmodule

// File: tb/tb_ccsds123_stim_gen.sv
// Self-checking bench for ccsds123_stim_gen: vector table of image runs plus stall/abort/restart sequences.
module tb_ccsds123_stim_gen;

  localparam int unsigned D      = 16;
  localparam int unsigned NX     = 4;
  localparam int unsigned NY     = 4;
  localparam int unsigned NZ     = 16;
  localparam int unsigned N      = NX * NY * NZ;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int          BUDGET = 20000;

  logic         clk = 1'b0;
  logic         areset;
  logic         start;
  logic [1:0]   pattern_sel;
  logic [1:0]   throttle;
  logic [D-1:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tuser;
  logic         m_axis_tlast;
  logic         busy;
  logic         done;
`ifdef CCSDS123_STIM_CHECKSUM_EN
  logic [31:0]  checksum;
`endif

  always #5 clk = ~clk;

  ccsds123_stim_gen #(.D(D), .NX(NX), .NY(NY), .NZ(NZ), .SEED(SEED)) dut (
    .clk          (clk),
    .areset       (areset),
    .start        (start),
    .pattern_sel  (pattern_sel),
    .throttle     (throttle),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy),
    .done         (done)
`ifdef CCSDS123_STIM_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [D-1:0] exp_data [N];

  typedef struct packed {
    logic [1:0]   pat;
    logic [1:0]   thr;
    logic [7:0]   rdy;
    logic         bub;
    logic         chk_last;
    logic [D-1:0] first;
    logic [D-1:0] last;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected sample per linear index, straight from the pattern definitions
  task automatic build_model(input logic [1:0] pat);
    logic [15:0] l;
    int x, y, z;
    l = SEED;
    for (int k = 0; k < int'(N); k++) begin
      z = k % int'(NZ);
      x = (k / int'(NZ)) % int'(NX);
      y = k / int'(NZ * NX);
      case (pat)
        2'd0: exp_data[k] = D'(k);
        2'd1: exp_data[k] = {D{1'b1}};
        2'd2: begin
          exp_data[k] = D'(l);
          l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        end
        default: exp_data[k] = (((x ^ y ^ z) & 1) == 1) ? {D{1'b1}} : {D{1'b0}};
      endcase
    end
  endtask

  task automatic run_image(input logic [1:0] pat, input logic [1:0] thr, input int rdy_pct,
                           input int stall_at, input int start_at, input int abort_at,
                           output int beats, output int dones, output int bubbles,
                           output logic [D-1:0] first_d, output logic [D-1:0] last_d,
                           output bit aborted);
    int cyc, stall_left;
    bit fin, pv;
    logic [D+2:0] pbeat;
    logic [31:0] sum;
    build_model(pat);
    beats = 0; dones = 0; bubbles = 0; first_d = '0; last_d = '0; aborted = 0;
    cyc = 0; stall_left = 5; fin = 0; pv = 0; sum = '0; pbeat = '0;
    pattern_sel = pat; throttle = thr; start = 1'b1;
    step();
    start = 1'b0;
    pattern_sel = ~pat; throttle = ~thr;
    check("busy_in_run", busy, 1'b1);
    while (!fin && !aborted && cyc < BUDGET) begin
      if (abort_at >= 0 && beats == abort_at) begin
        m_axis_tready = 1'b0;
        areset = 1'b1;
        #1;
        check("reset_mid_outputs", {m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast, busy, done}, '0);
        step();
        check("reset_held_outputs", {m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast, busy, done}, '0);
        areset = 1'b0;
        for (int i = 0; i < 4; i++) begin
          step();
          dones += int'(done);
          check("idle_after_abort", {busy, done, m_axis_tvalid}, '0);
        end
        aborted = 1;
      end else begin
        if (pv) check("hold_stable", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, pbeat);
        dones += int'(done);
        if (beats > 0 && !m_axis_tvalid) bubbles++;
        start = (beats == start_at);
        if (stall_at == beats && m_axis_tvalid && stall_left > 0) begin
          m_axis_tready = 1'b0;
          stall_left--;
          check("stall_data", m_axis_tdata, D'(stall_at));
        end else begin
          m_axis_tready = (int'($urandom_range(99)) < rdy_pct);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          check("beat_data", m_axis_tdata, exp_data[beats]);
          check("beat_user", m_axis_tuser, beats == 0);
          check("beat_last", m_axis_tlast, beats == int'(N) - 1);
          if (beats == 0) first_d = m_axis_tdata;
          if (m_axis_tlast || beats == int'(N) - 1) begin
            fin = 1;
            last_d = m_axis_tdata;
          end
          sum += 32'(m_axis_tdata);
          beats++;
        end
        pv = m_axis_tvalid && !m_axis_tready;
        pbeat = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata};
        step();
        cyc++;
      end
    end
    start = 1'b0;
    m_axis_tready = 1'b0;
    if (!aborted) begin
      check("finished_in_budget", fin, 1'b1);
      if (fin) begin
        check("done_after_tlast", done, 1'b1);
        check("busy_in_done", busy, 1'b1);
        dones += int'(done);
`ifdef CCSDS123_STIM_CHECKSUM_EN
        check("checksum", checksum, sum);
`endif
        for (int i = 0; i < 4; i++) begin
          step();
          dones += int'(done);
        end
        check("idle_after_image", {busy, m_axis_tvalid}, '0);
      end
    end
  endtask

  initial begin
    int beats, dones, bubbles;
    logic [D-1:0] first_d, last_d;
    bit aborted;

    vecs[0] = '{2'd0, 2'd0, 8'd100, 1'b0, 1'b1, 16'h0000, 16'h00FF};
    vecs[1] = '{2'd1, 2'd1, 8'd70,  1'b1, 1'b1, 16'hFFFF, 16'hFFFF};
    vecs[2] = '{2'd2, 2'd2, 8'd50,  1'b1, 1'b0, 16'hACE1, 16'h0000};
    vecs[3] = '{2'd3, 2'd0, 8'd100, 1'b0, 1'b1, 16'h0000, 16'hFFFF};
    vecs[4] = '{2'd0, 2'd3, 8'd50,  1'b1, 1'b1, 16'h0000, 16'h00FF};
    vecs[5] = '{2'd3, 2'd3, 8'd60,  1'b1, 1'b1, 16'h0000, 16'hFFFF};

    areset = 1'b1; start = 1'b0; pattern_sel = '0; throttle = '0; m_axis_tready = 1'b0;
    step();
    step();
    check("reset_outputs", {m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast, busy, done}, '0);
    areset = 1'b0;
    step();
    check("idle_outputs", {m_axis_tvalid, busy, done}, '0);

    for (int i = 0; i < 6; i++) begin
      run_image(vecs[i].pat, vecs[i].thr, int'(vecs[i].rdy), -1, -1, -1,
                beats, dones, bubbles, first_d, last_d, aborted);
      check("vec_beats", beats, N);
      check("vec_dones", dones, 1);
      check("vec_first", first_d, vecs[i].first);
      if (vecs[i].chk_last) check("vec_last", last_d, vecs[i].last);
      if (vecs[i].bub) check("vec_has_gaps", bubbles > 0, 1'b1);
      else check("vec_no_bubbles", bubbles, 0);
    end

    // stall at index 37
    run_image(2'd0, 2'd0, 100, 37, -1, -1, beats, dones, bubbles, first_d, last_d, aborted);
    check("stall_beats", beats, N);
    check("stall_dones", dones, 1);

    // reset after 100 handshakes, then a fresh image
    run_image(2'd0, 2'd1, 100, -1, -1, 100, beats, dones, bubbles, first_d, last_d, aborted);
    check("abort_taken", aborted, 1'b1);
    check("abort_beats", beats, 100);
    check("abort_no_done", dones, 0);
    run_image(2'd0, 2'd1, 80, -1, -1, -1, beats, dones, bubbles, first_d, last_d, aborted);
    check("restart_beats", beats, N);
    check("restart_first", first_d, 16'h0000);
    check("restart_dones", dones, 1);

    // start pulsed mid-image is ignored
    run_image(2'd0, 2'd0, 100, -1, 50, -1, beats, dones, bubbles, first_d, last_d, aborted);
    check("restart_ign_beats", beats, N);
    check("restart_ign_dones", dones, 1);
    run_image(2'd2, 2'd2, 75, -1, 120, -1, beats, dones, bubbles, first_d, last_d, aborted);
    check("restart_ign2_beats", beats, N);
    check("restart_ign2_dones", dones, 1);

`ifdef CCSDS123_STIM_CHECKSUM_EN
    run_image(2'd0, 2'd0, 100, -1, -1, -1, beats, dones, bubbles, first_d, last_d, aborted);
    check("ramp_checksum", checksum, 32'd32640);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ccsds123_stim_gen.md
CCSDS123_STIM_GEN -- requirements
Module: ccsds123_stim_gen

Interface
REQ-001 SHALL have parameter D, default 16: sample width in bits.
REQ-002 SHALL have parameters NX, NY, NZ, defaults 4, 4, 16: image columns, rows and bands.
REQ-003 SHALL have parameter SEED, default 16'hACE1: nonzero seed for the 16-bit data LFSR and the 16-bit gap LFSR.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port areset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle request to begin one image.
REQ-007 SHALL have port pattern_sel, input, 2: data pattern (0 ramp, 1 constant all-ones, 2 LFSR, 3 checkerboard).
REQ-008 SHALL have port throttle, input, 2: valid-gap density (0 none, 3 heaviest).
REQ-009 SHALL have port m_axis_tdata, output, D: sample.
REQ-010 SHALL have ports m_axis_tvalid (output, 1) and m_axis_tready (input, 1): AXI-Stream handshake.
REQ-011 SHALL have port m_axis_tuser, output, 1: first sample of the image.
REQ-012 SHALL have port m_axis_tlast, output, 1: last sample of the image.
REQ-013 SHALL have ports busy (output, 1) and done (output, 1, pulse).

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE -> RUN: start=1.
- RUN -> DONE: handshake with m_axis_tlast=1.
- DONE -> IDLE: unconditionally, after one cycle.
REQ-015 SHALL ignore start outside IDLE.
REQ-016 SHALL latch pattern_sel and throttle on the IDLE->RUN transition and hold them for the whole image.
REQ-017 SHALL emit NX*NY*NZ samples in BIP order: z fastest, then x, then y; counters wrap to 0 at NZ-1, NX-1 and NY-1 respectively.
REQ-018 SHALL assert m_axis_tvalid no earlier than the first cycle in RUN.
REQ-019 SHALL, once m_axis_tvalid=1, hold tvalid, tdata, tuser and tlast stable until the cycle m_axis_tready=1.
REQ-020 SHALL advance the index on a handshake (tvalid & tready) only.
REQ-021 SHALL gate new beats by gap-LFSR eligibility, advancing the gap LFSR every RUN cycle:
- throttle 0: always eligible.
- throttle 1: eligible when lfsr[0]=1.
- throttle 2: eligible when lfsr[1:0]=0.
- throttle 3: eligible when lfsr[2:0]=0.
REQ-022 SHALL, with throttle 0 and tready held 1, present a new beat every cycle with no bubbles.
REQ-023 SHALL generate data as follows:
- ramp: linear index mod 2^D.
- constant: all ones.
- LFSR: Fibonacci x^16+x^14+x^13+x^11+1 from SEED, stepped per handshake, zero-extended or truncated to D.
- checkerboard: all ones when (x^y^z)[0]=1, else 0.
REQ-024 SHALL assert m_axis_tuser only on index 0 and m_axis_tlast only on index NX*NY*NZ-1.
REQ-025 SHALL, when NX=NY=NZ=1, assert tuser and tlast on the same single beat.
REQ-026 SHALL assert busy in RUN and DONE, and pulse done for exactly the one DONE cycle, i.e. the cycle after the tlast handshake.
REQ-027 SHALL reseed both LFSRs to SEED on every IDLE->RUN transition.

Reset
REQ-028 SHALL, on areset=1, immediately force state IDLE and all outputs 0 (tdata, tvalid, tuser, tlast, busy, done), zero the counters and load both LFSRs with SEED.
REQ-029 SHALL, on reset asserted mid-image, abandon the image with no completion pulse; the next start begins again at index 0.

Configuration
REQ-030 SHALL, with macro CCSDS123_STIM_CHECKSUM_EN defined, add output checksum[31:0] holding the sum mod 2^32 of all handshaken samples since the last IDLE->RUN; reset and start clear it to 0.
REQ-031 SHALL, without CCSDS123_STIM_CHECKSUM_EN, omit the checksum port and logic; all other behaviour is identical.

Verification
REQ-032 Ramp, throttle 0, tready=1, 4x4x16 -> 256 consecutive beats with data 0..255, tuser on beat 0, tlast on beat 255, done one cycle later.
REQ-033 Ramp, tready low for 5 cycles while tvalid=1 at index 37 -> tdata holds 37 throughout the stall; the next beat carries 38.
REQ-034 Throttle 3, random tready -> exactly 256 handshakes; data sequence identical to REQ-032.
REQ-035 Reset pulsed after handshake 100, then start -> outputs 0 during reset, no done pulse, restarted stream begins at data 0 with tuser.
REQ-036 start pulsed during RUN -> ignored; beat count stays 256 and exactly one done pulse.
REQ-037 CCSDS123_STIM_CHECKSUM_EN defined, ramp image -> checksum=32640 at done.
